// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end to one shared 32-bit rotate-right barrel
// shifter; ARM-style LSL/LSR/ASR/ROR/RRX through a 2-stage valid/ready pipeline.
module shift_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [7:0]  req0_amt,
  input  logic [2:0]  req0_type,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [7:0]  req1_amt,
  input  logic [2:0]  req1_type,
  input  logic        req1_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_id
);

  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROR = 3'd3,
    SH_RRX = 3'd4
  } shift_op_e;

  logic        s1_valid;
  logic [31:0] s1_data;
  logic [7:0]  s1_amt;
  logic [2:0]  s1_type;
  logic        s1_cin;
  logic        s1_id;
  logic        last_grant;  // 1: requester 1 was granted most recently

  logic grant0, grant1, s2_load, s1_load, accept;

  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    s2_load    = ~rsp_valid | rsp_ready;
    s1_load    = ~s1_valid | s2_load;
    req0_ready = rst_n & grant0 & s1_load;
    req1_ready = rst_n & grant1 & s1_load;
    accept     = req0_ready | req1_ready;
  end

  shift_op_e   s1_op;
  logic [4:0]  r5, rot_amt;
  logic [31:0] rot_out, mask, res;
  logic        res_carry, zero_amt, big;

  assign s1_op = shift_op_e'(s1_type);

  always_comb begin
    r5        = s1_amt[4:0];
    zero_amt  = (s1_amt == '0);
    big       = |s1_amt[7:5];
    rot_amt   = '0;
    mask      = '1;
    res       = s1_data;
    res_carry = s1_cin;
    case (s1_op)
      SH_LSL:                 rot_amt = 5'd0 - r5;
      SH_LSR, SH_ASR, SH_ROR: rot_amt = r5;
      default:                rot_amt = '0;
    endcase
    // Single rotator; a left shift is a right rotate by 32-n followed by a mask.
    rot_out = (s1_data >> rot_amt) | (s1_data << (6'd32 - {1'b0, rot_amt}));
    case (s1_op)
      SH_LSL: if (!zero_amt) begin
        if (!big) begin
          mask      = 32'hFFFF_FFFF << r5;
          res       = rot_out & mask;
          res_carry = s1_data[5'd0 - r5];
        end else begin
          res       = '0;
          res_carry = (s1_amt == 8'd32) ? s1_data[0] : 1'b0;
        end
      end
      SH_LSR: if (!zero_amt) begin
        if (!big) begin
          mask      = 32'hFFFF_FFFF >> r5;
          res       = rot_out & mask;
          res_carry = s1_data[r5 - 5'd1];
        end else begin
          res       = '0;
          res_carry = (s1_amt == 8'd32) ? s1_data[31] : 1'b0;
        end
      end
      SH_ASR: if (!zero_amt) begin
        if (!big) begin
          mask      = 32'hFFFF_FFFF >> r5;
          res       = (rot_out & mask) | ({32{s1_data[31]}} & ~mask);
          res_carry = s1_data[r5 - 5'd1];
        end else begin
          res       = {32{s1_data[31]}};
          res_carry = s1_data[31];
        end
      end
      SH_ROR: if (!zero_amt) begin
        res       = rot_out;
        res_carry = rot_out[31];
      end
      SH_RRX: begin
        res       = {s1_cin, s1_data[31:1]};
        res_carry = s1_data[0];
      end
      default: begin
        res       = s1_data;
        res_carry = s1_cin;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_amt     <= '0;
      s1_type    <= '0;
      s1_cin     <= 1'b0;
      s1_id      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      if (accept) last_grant <= req1_ready;
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= req1_ready ? req1_data : req0_data;
          s1_amt  <= req1_ready ? req1_amt  : req0_amt;
          s1_type <= req1_ready ? req1_type : req0_type;
          s1_cin  <= req1_ready ? req1_cin  : req0_cin;
          s1_id   <= req1_ready;
        end
      end
      if (s2_load) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_data  <= res;
          rsp_carry <= res_carry;
          rsp_id    <= s1_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases plus random traffic
// against an arithmetic shift model and an occupancy-based pipeline model.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_data;
  logic [7:0]  req0_amt;
  logic [2:0]  req0_type;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_data;
  logic [7:0]  req1_amt;
  logic [2:0]  req1_type;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_id;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_type(req0_type), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_type(req1_type), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_id(rsp_id)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        carry;
    logic        id;
  } item_t;

  item_t       q[$];
  logic        ptr = 1'b1;  // 1 means requester 1 was served last
  logic        held = 1'b0;
  item_t       held_val;
  int unsigned acc_count = 0;
  int unsigned pop_count = 0;

  function automatic logic [32:0] ref_shift(input logic [2:0] t, input logic [31:0] d,
                                            input logic [7:0] n, input logic c);
    logic [64:0]        w;
    logic [63:0]        u;
    logic signed [63:0] s;
    logic [31:0]        r;
    int unsigned        m;
    case (t)
      3'd0: begin
        if (n == 0) return {c, d};
        w = {33'b0, d} << n;
        return {w[32], w[31:0]};
      end
      3'd1: begin
        if (n == 0) return {c, d};
        u = {d, 32'b0} >> n;
        return {u[31], u[63:32]};
      end
      3'd2: begin
        if (n == 0) return {c, d};
        m = (n > 63) ? 63 : int'(n);
        s = $signed({d, 32'b0});
        s = s >>> m;
        return {s[31], s[63:32]};
      end
      3'd3: begin
        if (n == 0) return {c, d};
        m = int'(n) % 32;
        r = (m == 0) ? d : ((d >> m) | (d << (32 - m)));
        return {r[31], r};
      end
      3'd4:    return {d[0], c, d[31:1]};
      default: return {c, d};
    endcase
  endfunction

  // One clock cycle: check combinational/registered outputs against the model,
  // advance the model, then return at the following falling edge.
  task automatic step();
    logic        can, g0, g1;
    item_t       it, e;
    logic [32:0] r;
    #1;
    if (!rst_n) begin
      check_eq("ready0_in_reset", {31'b0, req0_ready}, 0);
      check_eq("ready1_in_reset", {31'b0, req1_ready}, 0);
    end else begin
      can = (q.size() < 2) || rsp_ready;
      g0  = req0_valid && (!req1_valid || ptr);
      g1  = req1_valid && (!req0_valid || !ptr);
      check_eq("ready0", {31'b0, req0_ready}, {31'b0, g0 && can});
      check_eq("ready1", {31'b0, req1_ready}, {31'b0, g1 && can});
      if (q.size() == 0) check_eq("rsp_valid_when_empty", {31'b0, rsp_valid}, 0);
      if (held) begin
        check_eq("hold_valid", {31'b0, rsp_valid}, 1);
        check_eq("hold_data", rsp_data, held_val.data);
        check_eq("hold_carry", {31'b0, rsp_carry}, {31'b0, held_val.carry});
        check_eq("hold_id", {31'b0, rsp_id}, {31'b0, held_val.id});
      end
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        e = q.pop_front();
        pop_count++;
        check_eq("rsp_data", rsp_data, e.data);
        check_eq("rsp_carry", {31'b0, rsp_carry}, {31'b0, e.carry});
        check_eq("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
      end
      if (g0 && can) begin
        r = ref_shift(req0_type, req0_data, req0_amt, req0_cin);
        it.data = r[31:0]; it.carry = r[32]; it.id = 1'b0;
        q.push_back(it);
        ptr = 1'b0;
        acc_count++;
      end else if (g1 && can) begin
        r = ref_shift(req1_type, req1_data, req1_amt, req1_cin);
        it.data = r[31:0]; it.carry = r[32]; it.id = 1'b1;
        q.push_back(it);
        ptr = 1'b1;
        acc_count++;
      end
      held     = rsp_valid && !rsp_ready;
      held_val = {rsp_data, rsp_carry, rsp_id};
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ptr  = 1'b1;
      held = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input logic v, input logic [2:0] t,
                         input logic [31:0] d, input logic [7:0] n, input logic c);
    if (idx == 0) begin
      req0_valid = v; req0_type = t; req0_data = d; req0_amt = n; req0_cin = c;
    end else begin
      req1_valid = v; req1_type = t; req1_data = d; req1_amt = n; req1_cin = c;
    end
  endtask

  task automatic rand_req(input int idx, input logic v);
    logic [7:0] n;
    case ($urandom_range(0, 5))
      0:       n = 8'd0;
      1:       n = 8'd1;
      2:       n = 8'd31;
      3:       n = 8'd32;
      4:       n = 8'd33;
      default: n = 8'($urandom_range(0, 255));
    endcase
    set_req(idx, v, 3'($urandom_range(0, 7)), $urandom, n, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single req0 operation; the result must appear exactly two cycles after acceptance.
  task automatic run_one(input string tag, input logic [2:0] t, input logic [31:0] d,
                         input logic [7:0] n, input logic c,
                         input logic [31:0] ed, input logic ec);
    rsp_ready = 1'b1;
    set_req(1, 1'b0, 3'd0, 32'd0, 8'd0, 1'b0);
    set_req(0, 1'b1, t, d, n, c);
    step();
    req0_valid = 1'b0;
    check_eq({tag, "_not_yet"}, {31'b0, rsp_valid}, 0);
    step();
    check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 1);
    check_eq({tag, "_data"}, rsp_data, ed);
    check_eq({tag, "_carry"}, {31'b0, rsp_carry}, {31'b0, ec});
    check_eq({tag, "_id"}, {31'b0, rsp_id}, 0);
    step();
  endtask

  initial begin
    int unsigned a0, p0;
    logic [2:0]  ty;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'd0, 32'd0, 8'd0, 1'b0);
    set_req(1, 1'b1, 3'd0, 32'd0, 8'd0, 1'b0);
    @(negedge clk);
    step();
    step();
    check_eq("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check_eq("reset_rsp_data", rsp_data, 0);
    check_eq("reset_rsp_carry", {31'b0, rsp_carry}, 0);
    check_eq("reset_rsp_id", {31'b0, rsp_id}, 0);
    rst_n = 1'b1;

    run_one("lsl3",      3'd0, 32'h0000_0008, 8'd3,  1'b0, 32'h0000_0040, 1'b0);
    run_one("ror3",      3'd3, 32'h0000_0008, 8'd3,  1'b0, 32'h0000_0001, 1'b0);
    run_one("ror4",      3'd3, 32'h0000_0008, 8'd4,  1'b0, 32'h8000_0000, 1'b1);
    run_one("lsr32",     3'd1, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1);
    run_one("asr40",     3'd2, 32'h8000_0000, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_one("lsl33",     3'd0, 32'h0000_0001, 8'd33, 1'b0, 32'h0000_0000, 1'b0);
    run_one("ror32",     3'd3, 32'h1234_5678, 8'd32, 1'b0, 32'h1234_5678, 1'b0);
    run_one("rrx",       3'd4, 32'h0000_0003, 8'd0,  1'b1, 32'h8000_0001, 1'b1);
    run_one("lsr31",     3'd1, 32'h8000_0000, 8'd31, 1'b0, 32'h0000_0001, 1'b0);
    run_one("asr1",      3'd2, 32'h8000_0003, 8'd1,  1'b0, 32'hC000_0001, 1'b1);
    for (int t = 0; t < 8; t++) begin
      if (t == 4) continue;
      ty = 3'(t);
      run_one($sformatf("amt0_t%0d", t), ty, 32'hA5C3_0F96, 8'd0, 1'b1, 32'hA5C3_0F96, 1'b1);
    end

    // Tie after reset alternates starting with req0, one result per cycle.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_req(0, i < 6);
      rand_req(1, i < 6);
      #1;
      if (i < 6) begin
        check_eq("alt_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 1 : 0);
        check_eq("alt_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 1 : 0);
      end
      if (i >= 2) begin
        check_eq("alt_rsp_valid", {31'b0, rsp_valid}, 1);
        check_eq("alt_rsp_id", {31'b0, rsp_id}, (i % 2 == 1) ? 1 : 0);
      end
      step();
    end

    // Backpressure: two operations fill S2 and S1, then req0 stalls.
    rsp_ready = 1'b0;
    a0 = acc_count;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_req(0, 1'b1);
      #1;
      check_eq("bp_ready0", {31'b0, req0_ready}, (i < 2) ? 1 : 0);
      if (i >= 2) check_eq("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      step();
    end
    check_eq("bp_accepted", acc_count - a0, 2);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    p0 = pop_count;
    for (int i = 0; i < 3; i++) step();
    check_eq("bp_drained", pop_count - p0, 2);
    check_eq("bp_empty", {31'b0, rsp_valid}, 0);

    // Reset while both stages are full.
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_req(0, 1'b1);
      step();
    end
    check_eq("full_before_reset", {31'b0, rsp_valid}, 1);
    rst_n = 1'b0;
    rand_req(1, 1'b1);
    step();
    rst_n = 1'b1;
    check_eq("post_reset_valid", {31'b0, rsp_valid}, 0);
    check_eq("post_reset_data", rsp_data, 0);
    rsp_ready = 1'b1;
    rand_req(0, 1'b1);
    rand_req(1, 1'b1);
    #1;
    check_eq("post_reset_tie0", {31'b0, req0_ready}, 1);
    check_eq("post_reset_tie1", {31'b0, req1_ready}, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rand_req(0, 1'($urandom_range(0, 1)));
      rand_req(1, 1'($urandom_range(0, 1)));
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("final_idle", {31'b0, rsp_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester shift service for the CPU datapath, built around one shared 32-bit rotate-right barrel shifter (5-bit amount, 32-bit output, carry = output bit 31). It accepts ARM-style shift operations (LSL, LSR, ASR, ROR, RRX) with register-sized amounts 0–255 over valid/ready handshakes. It arbitrates round-robin between the operand-2 path (requester 0) and the immediate-rotate decoder (requester 1). It returns a shifted result plus shifter carry-out through a 2-stage pipeline with backpressure.

## Interface
- No parameters; data width fixed at 32, amount width fixed at 8.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- reqN_valid  in  1  requester N (N=0,1) has an operation
- reqN_ready  out  1  requester N's operation is accepted this cycle
- reqN_data  in  32  operand
- reqN_amt  in  8  shift amount, 0–255
- reqN_type  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5–7 reserved
- reqN_cin  in  1  current C flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  shifted result
- rsp_carry  out  1  shifter carry-out
- rsp_id  out  1  index of the requester that issued the result

## Operation
- Stage S1 is the capture register: data, amt, type, cin, id, valid.
- Stage S2 is the output register driving rsp_*.
- S2 loads when S2 is empty or rsp_ready=1.
- S1 loads when S1 is empty or S1 advances to S2.
- Arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not granted last.
  - The last-grant pointer resets to 1, so req0 wins the first tie.
  - The pointer updates only on an accepted handshake.
- reqN_ready = grantN & (S1 can load). The non-granted requester sees ready=0.
- reqN_ready is 0 while rst_n=0.
- Compute sits between S1 and S2 and uses the shared rotator. Shift amount n = amt; "fill" is a mask applied after rotation.
- LSL:
  - n=0: data, carry=cin.
  - n=1–31: rotate right by 32−n, zero the low n bits; carry=data[32−n].
  - n=32: 0, carry=data[0].
  - n>32: 0, carry=0.
- LSR:
  - n=0: data, cin.
  - n=1–31: rotate by n, zero the high n bits; carry=data[n−1].
  - n=32: 0, carry=data[31].
  - n>32: 0, 0.
- ASR:
  - n=0: data, cin.
  - n=1–31: rotate by n, fill the high n bits with data[31]; carry=data[n−1].
  - n≥32: all bits=data[31], carry=data[31].
- ROR:
  - n=0: data, cin.
  - n≠0 and n[4:0]=0: data, carry=data[31].
  - otherwise: rotate by n[4:0], carry=result[31].
- RRX: {cin, data[31:1]}, carry=data[0]; amt ignored.
- Reserved types: data unchanged, carry=cin.
- Requests complete in order; no reordering, no dropping while rst_n=1.

## Timing
- Reset (rst_n low at a clk edge) clears S1/S2 valid, the pointer goes to 1, and the outputs become: rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0.
- Reset mid-operation discards in-flight results; no response is issued for them.
- Latency: handshake in cycle N gives rsp_valid=1 in cycle N+2 when there is no backpressure.
- Throughput is 1 operation per cycle with rsp_ready held high.
- rsp_valid=1 with rsp_ready=0: rsp_* hold stable.
  - S1 may still fill once.
  - Then both ready outputs drop to 0 until S2 drains.
- Simultaneous S2 drain and S1 advance in the same cycle: no bubble.
- Simultaneous S1 fill and S1 advance in the same cycle: no bubble.
- Ready is combinational from the valids and pipeline state. rsp_* come directly from registers.

## Test plan
- Scalar results, each returned at N+2:
  - req0 LSL, data 0x00000008, amt 3 → rsp_data 0x00000040, carry 0, id 0.
  - ROR, amt 3 → 0x00000001, carry 0.
  - ROR, amt 4 → 0x80000000, carry 1.
- Boundary amounts:
  - LSR 0x80000001, amt 32 → 0x00000000, carry 1.
  - ASR 0x80000000, amt 40 → 0xFFFFFFFF, carry 1.
  - LSL 0x00000001, amt 33 → 0, carry 0.
  - ROR 0x12345678, amt 32 → 0x12345678, carry 0.
  - Any type with amt 0 and cin 1 → data, carry 1.
- RRX 0x00000003 with cin=1 → 0x80000001, carry 1.
- Both requesters valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; rsp_id follows the same order; one result per cycle.
- Backpressure: with rsp_ready=0 for 4 cycles and req0 streaming:
  - exactly 2 operations are held, in S2 and S1;
  - req0_ready is 0 thereafter;
  - rsp_* stay stable;
  - on release, results arrive in order with no loss.
- Reset with S1 and S2 full → next cycle rsp_valid=0, rsp_data=0; the following tie grants req0 first.
